// File: rtl/uart_dma_pkg.sv
// Shared constants and types for the UART DMA transmit buffer.
package uart_dma_pkg;

  // Drain policy selected by i_mode; any other encoding drains like MODE_PASS.
  localparam logic [1:0] MODE_PASS  = 2'd0;
  localparam logic [1:0] MODE_WM    = 2'd1;
  localparam logic [1:0] MODE_WM_TO = 2'd2;

  // Output FSM: one FIFO read, one load into the output register, then hold
  // until the UART takes the word.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_LOAD = 2'd2,
    ST_HOLD = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_dma_tx_ctrl_if.sv
// Byte-stream bundle: user write stream in, UART valid/ready stream out.
interface uart_dma_tx_ctrl_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] i_user_data;
  logic              i_user_valid;
  logic [DATA_W-1:0] o_tx_data;
  logic              o_tx_valid;
  logic              i_tx_ready;

  // Environment side: produces user words, consumes UART words.
  modport master (
    output i_user_data, i_user_valid, i_tx_ready,
    input  o_tx_data, o_tx_valid
  );

  // Buffer side.
  modport slave (
    input  i_user_data, i_user_valid, i_tx_ready,
    output o_tx_data, o_tx_valid
  );
endinterface

// File: rtl/sync_fifo_lvl.sv
// Single-clock FIFO with registered read data (1-cycle latency), occupancy
// counter, full/empty flags and drop-on-full write policy.
module sync_fifo_lvl #(
  parameter int   DATA_W = 8,
  parameter int   DEPTH  = 8192,
  localparam int  AW     = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [AW:0]       level,
  output logic              full,
  output logic              empty,
  output logic              drop
);

  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_ok;
  logic              rd_ok;

  // A write while full is lost even if a read frees a slot this same cycle.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;
  assign drop  = wr_en && full;
  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);

  // Storage array; contents are don't-care after reset since pointers clear.
  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Registered read port.
  always_ff @(posedge i_clk) begin
    if (rd_ok) rd_data <= mem[rd_ptr];
  end

  // Pointers and occupancy; simultaneous read and write keep level constant.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_dma_tx_ctrl.sv
// Byte buffer between user logic and the UART transmitter with selectable
// drain policy: passthrough, watermark, or watermark with idle-timeout flush.
module uart_dma_tx_ctrl
  import uart_dma_pkg::*;
#(
  parameter int  DATA_W      = 8,
  parameter int  DEPTH       = 8192,
  parameter int  TIMEOUT_CYC = 100000,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  uart_dma_tx_ctrl_if.slave   strm,
  input  logic [1:0]          i_mode,
  input  logic [AW:0]         i_watermark,
  input  logic                i_flush,
  input  logic                i_clr_ovf,
  output logic [AW:0]         o_level,
  output logic                o_full,
  output logic                o_empty,
  output logic                o_overflow,
  output logic                o_busy
);

  // Wide enough to hold TIMEOUT_CYC-1 even when TIMEOUT_CYC is 1.
  localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);

  // A watermark of zero would latch on an empty FIFO; treat it as one word.
  function automatic logic [AW:0] clamp_wm(input logic [AW:0] wm);
    return (wm == '0) ? {{AW{1'b0}}, 1'b1} : wm;
  endfunction

  tx_state_t         state;
  logic              rd_en_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              tx_valid_q;
  logic              latch_q;
  logic              ovf_q;
  logic [TW-1:0]     to_cnt;

  logic [DATA_W-1:0] rd_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_drop;
  logic [AW:0]       fifo_level;

  logic              mode_pass;
  logic              mode_to;
  logic              wr_acc;
  logic              to_hit;
  logic              latch_set;
  logic              elig;

  sync_fifo_lvl #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .wr_en   (strm.i_user_valid),
    .wr_data (strm.i_user_data),
    .rd_en   (rd_en_q),
    .rd_data (rd_data),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .drop    (fifo_drop)
  );

  assign mode_to   = (i_mode == MODE_WM_TO);
  assign mode_pass = (i_mode != MODE_WM) && !mode_to;
  assign wr_acc    = strm.i_user_valid && !fifo_full;

  // A write landing on the terminal count restarts the idle window instead.
  assign to_hit    = mode_to && !wr_acc && !fifo_empty && !latch_q &&
                     (to_cnt == TO_LAST);
  assign latch_set = (fifo_level >= clamp_wm(i_watermark)) || fifo_full || to_hit;
  assign elig      = !fifo_empty && (mode_pass || latch_q);

  // Drain latch: flush beats the empty clear, empty beats the other set causes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)           latch_q <= 1'b0;
    else if (i_flush)    latch_q <= 1'b1;
    else if (fifo_empty) latch_q <= 1'b0;
    else if (latch_set)  latch_q <= 1'b1;
  end

  // Idle timer: runs only in mode 2 while data waits and no drain is pending.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      to_cnt <= '0;
    end else if (!mode_to || wr_acc || fifo_empty || latch_q || to_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_ONE;
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)          ovf_q <= 1'b0;
    else if (fifo_drop) ovf_q <= 1'b1;
    else if (i_clr_ovf) ovf_q <= 1'b0;
  end

  // Output FSM: a started word always runs to its handshake; data is zero
  // whenever valid is low.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      rd_en_q    <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (elig) begin
            state   <= ST_RD;
            rd_en_q <= 1'b1;
          end
        end
        ST_RD: begin
          rd_en_q <= 1'b0;
          state   <= ST_LOAD;
        end
        ST_LOAD: begin
          tx_data_q  <= rd_data;
          tx_valid_q <= 1'b1;
          state      <= ST_HOLD;
        end
        ST_HOLD: begin
          if (strm.i_tx_ready) begin
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign strm.o_tx_data  = tx_data_q;
  assign strm.o_tx_valid = tx_valid_q;
  assign o_level         = fifo_level;
  assign o_full          = fifo_full;
  assign o_empty         = fifo_empty;
  assign o_overflow      = ovf_q;
  assign o_busy          = latch_q || (state != ST_IDLE);

endmodule

// File: tb/tb_uart_dma_tx_ctrl.sv
// Directed bench for uart_dma_tx_ctrl, built with DEPTH=16 and TIMEOUT_CYC=50.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_uart_dma_tx_ctrl;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int TO_CYC = 50;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic [4:0] watermark;
  logic       flush;
  logic       clr_ovf;
  logic [4:0] level;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       busy;

  int tests = 0;
  int fails = 0;

  uart_dma_tx_ctrl_if #(.DATA_W(DATA_W)) u_if ();

  uart_dma_tx_ctrl #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .strm        (u_if),
    .i_mode      (mode),
    .i_watermark (watermark),
    .i_flush     (flush),
    .i_clr_ovf   (clr_ovf),
    .o_level     (level),
    .o_full      (full),
    .o_empty     (empty),
    .o_overflow  (overflow),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       vld;
    logic [7:0] data;
    logic       rdy;
    logic [1:0] mode;
    logic       exp_txv;
    logic [7:0] exp_txd;
    logic [4:0] exp_lvl;
    logic       exp_empty;
  } vec_t;

  vec_t tbl [17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits for o_tx_valid; n is the cycle index at which it was seen, counting
  // the current cycle as 'start'.
  task automatic wait_valid(input int budget, input int start, output int n);
    n = start;
    while (!u_if.o_tx_valid && n < start + budget) begin
      tick();
      n++;
    end
    if (!u_if.o_tx_valid) begin
      tests++;
      fails++;
      $display("FAIL wait_valid: no o_tx_valid within %0d cycles", budget);
    end
  endtask

  // Collects cnt bytes expected to be first, first+1, ...; ready must be high.
  task automatic collect(input int cnt, input logic [7:0] first, input string name);
    for (int i = 0; i < cnt; i++) begin
      int w = 0;
      while (!u_if.o_tx_valid && w < 12) begin
        tick();
        w++;
      end
      check($sformatf("%s[%0d]", name, i), 32'({u_if.o_tx_valid, u_if.o_tx_data}),
            32'({1'b1, first + 8'(i)}));
      tick();
    end
  endtask

  task automatic write_word(input logic [7:0] d);
    u_if.i_user_valid = 1'b1;
    u_if.i_user_data  = d;
    tick();
    u_if.i_user_valid = 1'b0;
    u_if.i_user_data  = 8'h00;
  endtask

  int n;
  int seen;

  initial begin
    // Cycle-by-cycle passthrough vectors; the second half uses mode 3.
    //            vld   data   rdy   mode   txv   txd    lvl    empty
    tbl[0]  = '{1'b1, 8'hA5, 1'b1, 2'd0, 1'b0, 8'h00, 5'd0, 1'b1};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 8'h00, 5'd1, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 8'h00, 5'd1, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 8'h00, 5'd0, 1'b1};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 2'd0, 1'b1, 8'hA5, 5'd0, 1'b1};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 8'h00, 5'd0, 1'b1};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 2'd3, 1'b0, 8'h00, 5'd0, 1'b1};
    tbl[7]  = '{1'b1, 8'hB1, 1'b1, 2'd3, 1'b0, 8'h00, 5'd0, 1'b1};
    tbl[8]  = '{1'b1, 8'hC2, 1'b1, 2'd3, 1'b0, 8'h00, 5'd1, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 2'd3, 1'b0, 8'h00, 5'd2, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 2'd3, 1'b0, 8'h00, 5'd1, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 2'd3, 1'b1, 8'hB1, 5'd1, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 2'd3, 1'b0, 8'h00, 5'd1, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 2'd3, 1'b0, 8'h00, 5'd1, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 2'd3, 1'b0, 8'h00, 5'd0, 1'b1};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 2'd3, 1'b1, 8'hC2, 5'd0, 1'b1};
    tbl[16] = '{1'b0, 8'h00, 1'b1, 2'd3, 1'b0, 8'h00, 5'd0, 1'b1};

    rst               = 1'b1;
    mode              = 2'd0;
    watermark         = 5'd1;
    flush             = 1'b0;
    clr_ovf           = 1'b0;
    u_if.i_user_valid = 1'b0;
    u_if.i_user_data  = 8'h00;
    u_if.i_tx_ready   = 1'b1;
    tick();
    tick();

    // Reset state: {txv, txd, level, full, empty, ovf, busy}
    check("reset_state", 32'({u_if.o_tx_valid, u_if.o_tx_data, level, full, empty, overflow, busy}),
          32'({1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0}));
    rst = 1'b0;
    tick();

    // Table-driven passthrough: write at cycle 0 gives valid at cycle 4.
    for (int i = 0; i < 17; i++) begin
      u_if.i_user_valid = tbl[i].vld;
      u_if.i_user_data  = tbl[i].data;
      u_if.i_tx_ready   = tbl[i].rdy;
      mode              = tbl[i].mode;
      check($sformatf("vec%0d", i),
            32'({u_if.o_tx_valid, u_if.o_tx_data, level, empty}),
            32'({tbl[i].exp_txv, tbl[i].exp_txd, tbl[i].exp_lvl, tbl[i].exp_empty}));
      tick();
    end
    u_if.i_user_valid = 1'b0;
    mode              = 2'd0;

    // Backpressure: the held word must not move and no extra read may happen.
    u_if.i_tx_ready = 1'b0;
    write_word(8'hD4);
    write_word(8'hE5);
    wait_valid(10, 2, n);
    check("bp_latency", 32'(n), 32'd4);
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("bp_hold%0d", i), 32'({u_if.o_tx_valid, u_if.o_tx_data, level}),
            32'({1'b1, 8'hD4, 5'd1}));
    end
    u_if.i_tx_ready = 1'b1;
    tick();
    wait_valid(10, 1, n);
    check("bp_next_latency", 32'(n), 32'd4);
    check("bp_next_data", 32'(u_if.o_tx_data), 32'h0000_00E5);
    tick();
    check("bp_done", 32'({u_if.o_tx_valid, u_if.o_tx_data, empty}), 32'({1'b0, 8'h00, 1'b1}));

    // Watermark 16: fifteen words stay put, the sixteenth starts the drain.
    mode      = 2'd1;
    watermark = 5'd16;
    for (int i = 0; i < 15; i++) write_word(8'h10 + 8'(i));
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (u_if.o_tx_valid) seen++;
      tick();
    end
    check("wm_no_drain", 32'(seen), 32'd0);
    check("wm_level15", 32'(level), 32'd15);
    write_word(8'h1F);
    collect(16, 8'h10, "wm_byte");
    tick();
    tick();
    check("wm_idle", 32'({empty, busy}), 32'({1'b1, 1'b0}));

    // Watermark 0 acts as 1: one extra cycle versus passthrough for the latch.
    watermark = 5'd0;
    write_word(8'h5A);
    wait_valid(12, 1, n);
    check("wm0_latency", 32'(n), 32'd5);
    check("wm0_data", 32'(u_if.o_tx_data), 32'h0000_005A);
    tick();

    // Flush forces a drain below the watermark.
    watermark = 5'd20;
    write_word(8'h61);
    write_word(8'h62);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (u_if.o_tx_valid) seen++;
      tick();
    end
    check("flush_wait", 32'(seen), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    collect(2, 8'h61, "flush_byte");
    tick();
    tick();
    check("flush_idle", 32'({empty, busy}), 32'({1'b1, 1'b0}));

    // Timeout: last write in cycle k, counter 0..49 over cycles k+1..k+50,
    // latch seen k+51, RD k+52, LOAD k+53, valid k+54.
    mode = 2'd2;
    write_word(8'h31);
    write_word(8'h32);
    write_word(8'h33);
    wait_valid(80, 1, n);
    check("to_latency", 32'(n), 32'd54);
    check("to_first", 32'(u_if.o_tx_data), 32'h0000_0031);
    tick();
    collect(2, 8'h32, "to_byte");
    tick();
    check("to_idle", 32'({empty, busy}), 32'({1'b1, 1'b0}));

    // A write exactly when the counter reaches 49 restarts the idle window.
    write_word(8'h41);
    seen = 0;
    for (int i = 1; i < 50; i++) begin
      if (u_if.o_tx_valid) seen++;
      tick();
    end
    if (u_if.o_tx_valid) seen++;
    write_word(8'h42);
    check("to_restart_quiet", 32'(seen), 32'd0);
    wait_valid(80, 1, n);
    check("to_restart_latency", 32'(n), 32'd54);
    check("to_restart_first", 32'(u_if.o_tx_data), 32'h0000_0041);
    tick();
    collect(1, 8'h42, "to_restart_byte");

    // Overflow: words 17 and 18 dropped; clear on the last drop must lose.
    mode            = 2'd1;
    watermark       = 5'd20;
    u_if.i_tx_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      clr_ovf = (i == 17);
      write_word(8'h01 + 8'(i));
    end
    clr_ovf = 1'b0;
    check("ovf_status", 32'({level, full, overflow}), 32'({5'd16, 1'b1, 1'b1}));
    u_if.i_tx_ready = 1'b1;
    collect(16, 8'h01, "ovf_byte");
    tick();
    check("ovf_sticky", 32'({overflow, empty}), 32'({1'b1, 1'b1}));
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_clear", 32'(overflow), 32'd0);

    // Asynchronous reset while holding a word with five more buffered.
    mode            = 2'd0;
    u_if.i_tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) write_word(8'h81 + 8'(i));
    tick();
    check("pre_reset", 32'({u_if.o_tx_valid, u_if.o_tx_data, level}), 32'({1'b1, 8'h81, 5'd5}));
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", 32'({u_if.o_tx_valid, u_if.o_tx_data, level, empty, busy}),
          32'({1'b0, 8'h00, 5'd0, 1'b1, 1'b0}));
    tick();
    rst             = 1'b0;
    u_if.i_tx_ready = 1'b1;
    tick();
    write_word(8'h77);
    wait_valid(10, 1, n);
    check("post_reset_latency", 32'(n), 32'd4);
    check("post_reset_data", 32'(u_if.o_tx_data), 32'h0000_0077);
    tick();
    check("post_reset_empty", 32'({u_if.o_tx_valid, empty}), 32'({1'b0, 1'b1}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
